elastic_pipeline: RTL

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

---
 rtl/elastic_pipeline_pkg.sv | 24 ++
 rtl/elastic_pipeline_pipe_stage.sv | 58 +++++
 rtl/elastic_pipeline.sv | 96 +++++++++
 3 files changed

// File: rtl/elastic_pipeline_pkg.sv
// elastic_pipeline_pkg
//   Shared constants and helpers for the elastic pipeline:
//   - DEF_WIDTH / DEF_DEPTH : default data width and stage count
//   - clog2()               : ceiling log2, used to size the occupancy counter
package elastic_pipeline_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Smallest n with 2**n >= value; value is expected to be >= 2 here.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/elastic_pipeline_pipe_stage.sv
// pipe_stage
//   One valid/data register pair of the elastic pipeline.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     flush         : synchronous clear of the valid bit
//     load_i        : stage is ready; capture valid_i/data_i on this edge
//     valid_i/data_i: predecessor stage (or upstream input for stage 0)
//     valid_o/data_o: registered stage contents
//     valid_next_o  : valid bit that will be captured on the next edge
module pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_next_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Next-state: flush wins, otherwise load when ready, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      // Data is left untouched; a cleared valid bit makes it don't-care.
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign valid_next_o = valid_d;

endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline
//   DEPTH-stage valid/ready pipeline whose empty stages (bubbles) collapse
//   forward even while the output is stalled.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     flush               : synchronous clear of every stage
//     in_valid/in_data    : upstream word, in_ready accepts it
//     out_valid/out_data  : word in the last stage, out_ready consumes it
//     occupancy           : registered count of valid stages
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = clog2(DEPTH+1);

  logic [DEPTH-1:0] stage_v_s;
  logic [DEPTH-1:0] stage_v_next_s;
  logic [WIDTH-1:0] stage_d_s [DEPTH];
  logic [DEPTH:0]   ready_s;
  logic [OCC_W-1:0] occ_d, occ_q;

  // Ready chain from the output back to the input: a stage can take a new
  // word if it is empty or its successor is moving.
  always_comb begin
    ready_s        = '0;
    ready_s[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready_s[k] = ~stage_v_s[k] | ready_s[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             vin_s;
    logic [WIDTH-1:0] din_s;

    if (k == 0) begin : g_head
      assign vin_s = in_valid;
      assign din_s = in_data;
    end else begin : g_body
      assign vin_s = stage_v_s[k-1];
      assign din_s = stage_d_s[k-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .load_i       (ready_s[k]),
      .valid_i      (vin_s),
      .data_i       (din_s),
      .valid_o      (stage_v_s[k]),
      .data_o       (stage_d_s[k]),
      .valid_next_o (stage_v_next_s[k])
    );
  end

  // Population count of the next valid vector, so occupancy lands on the
  // same edge as the stage valid bits.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(stage_v_next_s[k]);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign in_ready  = ready_s[0] & ~flush;
  assign out_valid = stage_v_s[DEPTH-1];
  assign out_data  = stage_d_s[DEPTH-1];
  assign occupancy = occ_q;

endmodule
